// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address check for the DMEM responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    // Callers zero-extend their address to 64 bits so one function serves any ADDR_W up to 64.
    function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] depth_words);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[ADDR_LSB-1:0] != '0);
        out_of_range = ((addr >> ADDR_LSB) >= depth_words);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word RAM with per-byte write enables and combinational read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] wstrb,
    input  logic [IDX_W-1:0]      idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (we && wstrb[i]) begin
                mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding DMEM responder with wait states and error flagging
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [WORD_BYTES-1:0] req_wstrb,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [WORD_BYTES-1:0] wstrb_q, wstrb_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  acc_err;
    logic                  mem_we;
    logic [31:0]           mem_rdata;

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .wstrb (wstrb_q),
        .idx   (addr_q[ADDR_LSB +: IDX_W]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        acc_err     = addr_err(64'(addr_q), 64'(DEPTH_WORDS));

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge: the RAM write and the response capture happen together.
                    mem_we      = we_q && !acc_err;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || we_q) ? 32'h0 : mem_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            wstrb_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (WAIT_STATES 2 and 0)
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic        req_valid1, req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .ADDR_W(32)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid1),
        .rsp_rdata (rsp_rdata1),
        .rsp_err   (rsp_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT_STATES=2 instance, with timing checks built in.
    task automatic run0(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input logic toggle,
                        output logic [31:0] rdata, output logic err);
        int n;
        int lat;
        int rdy_at;
        int pulses;
        @(negedge clk);
        n = 0;
        while (req_ready0 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_wait"}, 32'(n < 20), 32'd1);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wstrb  = wstrb;
        req_valid0 = 1'b1;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        if (toggle) begin
            req_we    = ~we;
            req_addr  = 32'h0000_0013;
            req_wdata = 32'hA5A5_5A5A;
            req_wstrb = ~wstrb;
        end
        lat    = 0;
        rdy_at = 0;
        pulses = 0;
        rdata  = 32'h0;
        err    = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (toggle && k == 2) begin
                req_addr  = 32'h0000_0100;
                req_wdata = 32'h1357_9BDF;
            end
            if (rsp_valid0) begin
                pulses++;
                if (lat == 0) begin
                    lat   = k;
                    rdata = rsp_rdata0;
                    err   = rsp_err0;
                end
            end
            if (req_ready0 && rdy_at == 0) rdy_at = k;
        end
        chk({tag, "_rsp_latency"}, 32'(lat), 32'd4);
        chk({tag, "_ready_return"}, 32'(rdy_at), 32'd5);
        chk({tag, "_rsp_pulses"}, 32'(pulses), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          pulses;
        int          acc[$];
        int          rsp[$];

        rst        = 1'b1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;

        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(req_ready0), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("reset_rdata", rsp_rdata0, 32'h0);
        chk("reset_err", 32'(rsp_err0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready0), 32'd1);

        run0("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er);
        chk("st_full_rdata", rd, 32'h0);
        chk("st_full_err", 32'(er), 32'd0);
        run0("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er);
        chk("ld_full_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_full_err", 32'(er), 32'd0);

        run0("st_bytes", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 1'b0, rd, er);
        run0("ld_bytes", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er);
        chk("ld_bytes_rdata", rd, 32'hDE22_BE44);

        run0("ld_misal", 1'b0, 32'h13, 32'h0, 4'h0, 1'b0, rd, er);
        chk("ld_misal_err", 32'(er), 32'd1);
        chk("ld_misal_rdata", rd, 32'h0);

        run0("st_w0", 1'b1, 32'h0, 32'h0102_0304, 4'hF, 1'b0, rd, er);
        run0("st_oor", 1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
        chk("st_oor_err", 32'(er), 32'd1);
        chk("st_oor_rdata", rd, 32'h0);
        run0("ld_w0", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er);
        chk("ld_w0_rdata", rd, 32'h0102_0304);
        chk("ld_w0_err", 32'(er), 32'd0);

        run0("st_nostrb", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b1, rd, er);
        chk("st_nostrb_err", 32'(er), 32'd0);
        run0("ld_toggle", 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er);
        chk("ld_toggle_rdata", rd, 32'hDE22_BE44);
        chk("ld_toggle_err", 32'(er), 32'd0);
        chk("rdata_hold", rsp_rdata0, 32'hDE22_BE44);

        run0("st_w8_zero", 1'b1, 32'h20, 32'h0, 4'hF, 1'b0, rd, er);
        @(negedge clk);
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'hCAFE_F00D;
        req_wstrb  = 4'hF;
        req_valid0 = 1'b1;
        chk("rst_store_ready", 32'(req_ready0), 32'd1);
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(req_ready0), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid0), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk("rst_release_ready", 32'(req_ready0), 32'd1);
            if (rsp_valid0) pulses++;
        end
        chk("rst_no_response", 32'(pulses), 32'd0);
        run0("ld_w8", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er);
        chk("ld_w8_rdata", rd, 32'h0);

        req_we   = 1'b0;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (req_ready1) acc.push_back(c);
            if (rsp_valid1) begin
                rsp.push_back(c);
                chk("w0_rsp_err", 32'(rsp_err1), 32'd0);
            end
        end
        req_valid1 = 1'b0;
        chk("w0_accept_count", 32'(acc.size() >= 3), 32'd1);
        chk("w0_rsp_count", 32'(rsp.size() >= 2), 32'd1);
        if (acc.size() >= 3 && rsp.size() >= 2) begin
            chk("w0_spacing_a", 32'(acc[1] - acc[0]), 32'd3);
            chk("w0_spacing_b", 32'(acc[2] - acc[1]), 32'd3);
            chk("w0_latency_a", 32'(rsp[0] - acc[0]), 32'd2);
            chk("w0_latency_b", 32'(rsp[1] - acc[1]), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
